// File: rtl/sm_display_driver.sv
//------------------------------------------------------------------------------
// Module   : sm_display_driver
// Purpose  : Sign-magnitude to 4-digit multiplexed common-anode 7-seg driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm_display_driver #(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       load,
    input  logic       sign,
    input  logic [7:0] mag,
    output logic       busy,
    output logic       done,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int         c_CNT_W = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;
    localparam logic [6:0] c_BLANK = 7'b1111111;
    localparam logic [6:0] c_DASH  = 7'b0111111;

    logic [1:0]         r_state;
    logic               r_sign;
    logic [7:0]         r_shift;
    logic [11:0]        r_bcd;
    logic [2:0]         r_bit_cnt;
    logic [3:0]         r_disp_h;
    logic [3:0]         r_disp_t;
    logic [3:0]         r_disp_o;
    logic               r_disp_neg;
    logic               r_valid;
    logic               r_done;
    logic [c_CNT_W-1:0] r_scan_cnt;
    logic [1:0]         r_scan_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic [11:0]        w_bcd_adj;
    logic [6:0]         w_digit_seg;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return c_BLANK;
        endcase
    endfunction

    always_comb begin
        w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    end

    // Conversion FSM: capture, eight shift-add-3 steps, then publish to display.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_state    <= c_IDLE;
            r_sign     <= 1'b0;
            r_shift    <= 8'd0;
            r_bcd      <= 12'd0;
            r_bit_cnt  <= 3'd0;
            r_disp_h   <= 4'd0;
            r_disp_t   <= 4'd0;
            r_disp_o   <= 4'd0;
            r_disp_neg <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        r_sign    <= sign;
                        r_shift   <= mag;
                        r_bcd     <= 12'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    {r_bcd, r_shift} <= {w_bcd_adj[10:0], r_shift, 1'b0};
                    r_bit_cnt        <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_state <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    r_disp_h   <= r_bcd[11:8];
                    r_disp_t   <= r_bcd[7:4];
                    r_disp_o   <= r_bcd[3:0];
                    r_disp_neg <= r_sign && (r_bcd != 12'd0);
                    r_valid    <= 1'b1;
                    r_done     <= 1'b1;
                    r_state    <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Leading-zero blanking; negative zero keeps the sign digit dark.
    always_comb begin
        w_digit_seg = c_BLANK;
        if (r_valid) begin
            case (r_scan_idx)
                2'd0: w_digit_seg = seg7(r_disp_o);
                2'd1: w_digit_seg = ((r_disp_h != 4'd0) || (r_disp_t != 4'd0)) ? seg7(r_disp_t) : c_BLANK;
                2'd2: w_digit_seg = (r_disp_h != 4'd0) ? seg7(r_disp_h) : c_BLANK;
                default: w_digit_seg = r_disp_neg ? c_DASH : c_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            r_scan_cnt <= '0;
            r_scan_idx <= 2'd0;
            r_an       <= 4'b1111;
            r_seg      <= c_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_scan_idx);
            r_seg <= w_digit_seg;
            if (r_scan_cnt == c_CNT_W'(SCAN_CYCLES - 1)) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    assign busy = (r_state != c_IDLE);
    assign done = r_done;
    assign an   = r_an;
    assign seg  = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_sm_display_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_sm_display_driver
// Purpose  : Self-checking bench with an arithmetic reference display model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_display_driver;

    localparam int SC = 4;

    logic       clk  = 1'b0;
    logic       ar   = 1'b1;
    logic       load = 1'b0;
    logic       sign = 1'b0;
    logic [7:0] mag  = 8'd0;
    logic       busy;
    logic       done;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    sm_display_driver #(.SCAN_CYCLES(SC)) dut (
        .clk  (clk),
        .ar   (ar),
        .load (load),
        .sign (sign),
        .mag  (mag),
        .busy (busy),
        .done (done),
        .an   (an),
        .seg  (seg)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state: edges since reset release, remaining busy edges,
    // value currently on the display and value awaiting publication.
    int         n_edges;
    int         busy_cnt;
    int         cyc = 0;
    int         done_count = 0;
    int         last_done;
    logic       m_valid;
    logic       m_neg;
    int         m_mag;
    logic       p_neg;
    int         p_mag;
    logic       exp_busy;
    logic       exp_done;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] digit_exp(input logic v, input logic neg, input int m, input int idx);
        if (!v) return 7'b1111111;
        case (idx)
            0: return seg_of(m % 10);
            1: return (m >= 10) ? seg_of((m / 10) % 10) : 7'b1111111;
            2: return (m >= 100) ? seg_of(m / 100) : 7'b1111111;
            default: return neg ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        n_edges  = 0;
        busy_cnt = 0;
        m_valid  = 1'b0;
        m_neg    = 1'b0;
        m_mag    = 0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_an   = 4'b1111;
        exp_seg  = 7'b1111111;
    endtask

    task automatic cycle();
        logic pv;
        logic pn;
        int   pm;
        int   idx;
        @(posedge clk);
        cyc++;
        if (!ar) begin
            model_reset();
        end else begin
            n_edges++;
            pv       = m_valid;
            pn       = m_neg;
            pm       = m_mag;
            exp_done = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    m_valid  = 1'b1;
                    m_mag    = p_mag;
                    m_neg    = p_neg && (p_mag != 0);
                    exp_done = 1'b1;
                end
            end else if (load) begin
                p_neg    = sign;
                p_mag    = int'(mag);
                busy_cnt = 9;
            end
            exp_busy = (busy_cnt != 0);
            idx      = ((n_edges - 1) / SC) % 4;
            exp_an   = ~(4'b0001 << idx);
            exp_seg  = digit_exp(pv, pn, pm, idx);
        end
        @(negedge clk);
        check("busy", {7'd0, busy}, {7'd0, exp_busy});
        check("done", {7'd0, done}, {7'd0, exp_done});
        check("an",   {4'd0, an},   {4'd0, exp_an});
        check("seg",  {1'b0, seg},  {1'b0, exp_seg});
        if (exp_done) done_count++;
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic convert(input logic s, input logic [7:0] m, input int tail);
        load = 1'b1;
        sign = s;
        mag  = m;
        cycle();
        load = 1'b0;
        run(9 + tail);
    endtask

    initial begin
        int dc0;
        model_reset();
        #1 ar = 1'b0;
        #1;
        check("rst_an",  {4'd0, an},  8'h0F);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        run(2);
        ar = 1'b1;
        run(20);

        convert(1'b1, 8'd64, 17);

        dc0  = done_count;
        load = 1'b1;
        sign = 1'b0;
        mag  = 8'd255;
        cycle();
        load = 1'b0;
        run(2);
        load = 1'b1;
        mag  = 8'd7;
        run(3);
        load = 1'b0;
        run(20);
        check("single_done", 8'(done_count - dc0), 8'd1);

        convert(1'b1, 8'd0, 17);
        convert(1'b0, 8'd105, 17);

        load = 1'b1;
        sign = 1'b0;
        mag  = 8'd200;
        cycle();
        load = 1'b0;
        run(4);
        ar = 1'b0;
        #1;
        check("arst_busy", {7'd0, busy}, 8'd0);
        check("arst_done", {7'd0, done}, 8'd0);
        check("arst_an",   {4'd0, an},   8'h0F);
        check("arst_seg",  {1'b0, seg},  8'h7F);
        model_reset();
        run(2);
        ar = 1'b1;
        run(3);
        convert(1'b0, 8'd200, 17);

        last_done = -1;
        load = 1'b1;
        sign = 1'b0;
        mag  = 8'd9;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (exp_done) begin
                if (last_done >= 0) check("done_period", 8'(cyc - last_done), 8'd10);
                last_done = cyc;
                mag = (mag == 8'd9) ? 8'd10 : 8'd9;
            end
        end
        load = 1'b0;
        run(12);

        for (int i = 0; i < 300; i++) begin
            load = ($urandom_range(0, 5) == 0);
            sign = 1'($urandom_range(0, 1));
            mag  = 8'($urandom_range(0, 255));
            cycle();
        end
        load = 1'b0;
        run(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm_display_driver.md
Name: sm_display_driver

Overview:
- Consumer end of the ALU result path: accepts a sign-magnitude result (sign bit plus 8-bit unsigned magnitude) and shows it on a 4-digit, multiplexed, common-anode 7-segment display.
- Converts the magnitude to three BCD digits with an iterative shift-add-3 engine (one bit per clock).
- Time-multiplexes four digits: sign, hundreds, tens, ones.
- Sits between the ALU outputs (sign, f_out, or a_mag/b_mag with signA/signB) and the board display pins.

Parameters:
- SCAN_CYCLES, default 50000: clocks each digit stays enabled before the scan advances. Must be ≥ 2. The bench uses 4.

Ports:
- clk   input  1  system clock; all state changes on posedge.
- ar    input  1  asynchronous, active-low reset.
- load  input  1  request to capture sign/mag. Sampled on posedge.
- sign  input  1  1 = negative.
- mag   input  8  unsigned magnitude, 0..255.
- busy  output 1  conversion in progress.
- done  output 1  one-cycle pulse when new digits reach the display.
- an    output 4  digit enables, active-low, one-hot. an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=sign.
- seg   output 7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Clock and reset: one clock (clk). Reset ar is asynchronous and active-low.
- Reset (ar=0, takes effect immediately, no clock needed):
  - state=IDLE, busy=0, done=0.
  - Shift and BCD work registers cleared.
  - Display digit registers cleared; valid flag=0.
  - Scan counter=0, scan index=0, an=4'b1111, seg=7'b1111111.
  - Reset mid-conversion aborts the conversion. The captured value is discarded.
- FSM states:
  - IDLE: if load=1 at posedge E0, capture sign and mag, clear the BCD accumulator (12 bits), clear the bit counter, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: on each of edges E1..E8, add 3 to every BCD nibble ≥ 5, then shift {bcd, mag_shift} left by one. After the 8th shift (E8), go to LATCH.
  - LATCH: at E9, copy hundreds/tens/ones and sign into the display registers, set valid=1, pulse done=1 for exactly one cycle, go to IDLE.
- Latency and handshake:
  - busy=1 exactly while state≠IDLE, i.e. after E0 through E9.
  - Fixed latency: 9 clocks from the accepting edge to done.
  - load while busy=1 is ignored. It is not queued.
  - load held high continuously restarts a conversion on the first IDLE edge after each done.
  - Display registers keep the previous value throughout SHIFT, so the display never shows partial results.
- Digit content (valid=1):
  - Ones: always shown.
  - Tens: blanked if hundreds=0 and tens=0.
  - Hundreds: blanked if 0.
  - Sign digit: shows '-' if sign=1 and mag≠0. Blank otherwise, so negative zero displays as "0".
  - valid=0: all digits blank, but the scan still runs.
- Segment codes (active-low, {g..a}):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - '-' = 0111111, blank = 1111111
- Scan:
  - The counter runs 0..SCAN_CYCLES-1 continuously, independent of the FSM.
  - On wrap, the scan index advances 0→1→2→3→0.
  - an = ~(1<<index), registered. seg is registered from the selected digit in the same cycle as an, so an and seg always change on the same edge.
  - The first an assertion (an=4'b1110) occurs on the first posedge after reset release.
- Arithmetic: shift-add-3 over 8 input bits yields a 12-bit BCD result. The maximum value 255 gives hundreds=2, tens=5, ones=5, so no overflow is possible.

Test Plan:
- Reset then idle, SCAN_CYCLES=4: an cycles 1110, 1101, 1011, 0111, with 4 clocks each; seg=1111111 on every digit; busy=0, done=0.
- load with sign=1, mag=8'd64: busy high 9 clocks; done pulses 9 clocks after the accepting edge. The scan then shows ones=0011001 (4), tens=0000010 (6), hundreds blank, sign=0111111.
- load with sign=0, mag=8'd255, then load=1 asserted during busy with mag=8'd7: the second load is ignored. Display shows 2/5/5 with the sign digit blank; only one done pulse occurs.
- load with sign=1, mag=0: ones=1000000; tens, hundreds and sign all blank. Then load sign=0, mag=8'd105: hundreds=1111001, tens=1000000 (zero not blanked because hundreds≠0), ones=0010010.
- Assert ar=0 at SHIFT cycle 4 of a conversion of 8'd200: outputs return to reset values asynchronously, before the next clock edge. No done pulse; display blank. After release, a fresh load of 8'd200 completes normally and shows 2/0/0.
- Hold load=1 continuously, changing mag between 8'd9 and 8'd10 once per conversion: done pulses every 10 clocks (9-clock latency plus one IDLE acceptance edge). Display alternates 9 and 10, with no partial value visible between done pulses.
